ddc_cfg_sequencer: RTL and testbench
====================================

DDC_CFG_SEQUENCER -- requirements
Module: ddc_cfg_sequencer

Interface
REQ-001 SHALL have parameter INT_NUMBER_OF_TAPS, default 5: number of FIR coefficients in the DDC.
REQ-002 SHALL have parameter INT_COEF_WIDTH, default 10: signed coefficient width.
REQ-003 SHALL have parameter INT_DOWNSAMPLING, default 10: maximum decimation ratio.
REQ-004 SHALL have parameter INT_FLUSH_SAMPLES, default INT_NUMBER_OF_TAPS: number of DDC output samples discarded after reconfiguration.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, exactly as follows:
  clk  in  1  single clock
  rst_n  in  1  asynchronous reset, active-low
REQ-006 SHALL have the following remaining ports:
  i_wr_valid  in  1  shadow coefficient write strobe
  o_wr_ready  out  1  shadow coefficient write accepted
  i_wr_addr  in  clog2(TAPS)  coefficient index
  i_wr_data  in  COEF_WIDTH signed  coefficient value
  i_deci_valid  in  1  shadow decimation write strobe
  i_deci_data  in  clog2(DOWNSAMPLING)  decimation ratio minus 1
  i_commit  in  1  apply-shadow request pulse
  o_fir_cmd_valid  out  1  DDC FIR coefficient write strobe
  o_fir_cmd_coeffsel  out  clog2(TAPS)  DDC coefficient index
  o_fir_cmd_data  out  COEF_WIDTH signed  DDC coefficient value
  o_deci_cmd_valid  out  1  DDC decimation write strobe
  o_deci_cmd_data  out  clog2(DOWNSAMPLING)  DDC decimation value
  i_ddc_valid  in  1  DDC output-valid strobe
  o_ddc_valid_gated  out  1  i_ddc_valid, masked during reconfiguration
  o_busy  out  1  high whenever the state is not IDLE
  o_done  out  1  one-cycle pulse when reconfiguration completes
  o_err  out  1  one-cycle pulse when a write is rejected

Function
REQ-007 SHALL hold the shadow registers COEF[0..TAPS-1] and DECI; a write is accepted when i_wr_valid && o_wr_ready, and the value is visible from the next cycle.
REQ-008 SHALL implement the states IDLE, LOAD_COEF, LOAD_DECI, FLUSH and DONE.
REQ-009 IDLE: on i_commit, or if the pending flag is set, SHALL go to LOAD_COEF next cycle, clear pending and reset the tap index k to 0.
REQ-010 LOAD_COEF: SHALL drive o_fir_cmd_valid=1, o_fir_cmd_coeffsel=k and o_fir_cmd_data=COEF[k] each cycle, incrementing k; after k=TAPS-1 it SHALL go to LOAD_DECI.
REQ-011 LOAD_DECI: SHALL drive o_deci_cmd_valid=1 and o_deci_cmd_data=DECI for exactly one cycle, clear the flush counter, then go to FLUSH.
REQ-012 FLUSH: SHALL increment the flush counter on each i_ddc_valid; when the counter reaches INT_FLUSH_SAMPLES it SHALL go to DONE; with INT_FLUSH_SAMPLES=0 it SHALL go to DONE after one cycle.
REQ-013 DONE: SHALL assert o_done for one cycle, then go to IDLE.
REQ-014 Timing: a commit sampled in IDLE at cycle t SHALL give FIR strobes at t+1..t+TAPS, the decimation strobe at t+TAPS+1, and FLUSH from t+TAPS+2.
REQ-015 SHALL drive o_ddc_valid_gated = i_ddc_valid && state==IDLE, combinationally.
REQ-016 SHALL drive o_wr_ready=0 in LOAD_COEF and 1 in all other states.
REQ-017 i_deci_valid SHALL be ignored in LOAD_DECI, with no error raised.
REQ-018 i_commit outside IDLE SHALL set the pending flag; multiple commits SHALL coalesce into one; the pending rerun SHALL start in the cycle after DONE, using the shadow contents at that time.
REQ-019 A write with i_wr_addr>=TAPS, or with i_deci_data>=INT_DOWNSAMPLING, SHALL be dropped and SHALL pulse o_err the next cycle, leaving the shadow registers unchanged.
REQ-020 Simultaneous coefficient and decimation writes SHALL both be applied (or each be checked and rejected independently); o_err SHALL be a single pulse.
REQ-021 A shadow write in the same cycle as a commit SHALL be included in that commit.
REQ-022 All command outputs (o_fir_cmd_*, o_deci_cmd_*) SHALL be driven to 0 whenever their valid is low.

Reset
REQ-023 Asserting rst_n low SHALL immediately, at any point (including mid-LOAD_COEF), force: state=IDLE, pending=0, k=0, flush counter=0, all COEF=0, DECI=INT_DOWNSAMPLING-1, and all outputs 0 except o_wr_ready=1.
REQ-024 SHALL issue no automatic commit after reset release.

Structure
REQ-025 The state enum typedef and the default parameter constants SHALL live in the shared package ddc_pkg.
REQ-026 The shadow register file, with its range check and o_err generation, SHALL be the sub-module ddc_cfg_shadow; the FSM and counters SHALL stay at the top level.

Verification
REQ-027 Write COEF = {1,2,3,4,5} and DECI=4, then commit at cycle t -> coeffsel 0..4 with data 1..5 at t+1..t+5, deci_cmd=4 at t+6.
REQ-028 After that commit, drive 5 i_ddc_valid pulses -> o_ddc_valid_gated stays 0 for all 5, then o_done pulses once and the next i_ddc_valid passes through.
REQ-029 Commit three times during FLUSH -> exactly one additional sequence, starting the cycle after DONE.
REQ-030 Write i_wr_addr=7 and i_deci_data=12 -> o_err pulse and shadow unchanged (read back via commit: values 0 and 9).
REQ-031 Assert rst_n low at the 3rd FIR strobe -> all strobes 0 immediately and shadow reset; no activity after release.
REQ-032 Write with wr_valid during LOAD_COEF -> o_wr_ready=0, the write is not taken, and it is accepted on the first cycle of LOAD_DECI.

Source files
------------

// File: rtl/ddc_pkg.sv
// Shared types and default constants for the DDC configuration sequencer.
// Holds the FSM state encoding and a width helper used by every block.
package ddc_pkg;

    localparam int DEF_NUMBER_OF_TAPS = 5;
    localparam int DEF_COEF_WIDTH     = 10;
    localparam int DEF_DOWNSAMPLING   = 10;

    typedef enum logic [2:0] {
        StIdle,
        StLoadCoef,
        StLoadDeci,
        StFlush,
        StDone
    } ddc_state_e;

    // Index width that never collapses to zero bits for tiny parameter values.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ddc_cfg_shadow.sv
// Shadow coefficient/decimation register file with range checking.
// Out-of-range writes are dropped and flagged by a one-cycle err pulse.
module ddc_cfg_shadow import ddc_pkg::*; #(
    parameter int INT_NUMBER_OF_TAPS = DEF_NUMBER_OF_TAPS,
    parameter int INT_COEF_WIDTH     = DEF_COEF_WIDTH,
    parameter int INT_DOWNSAMPLING   = DEF_DOWNSAMPLING,
    localparam int AW = clog2_min1(INT_NUMBER_OF_TAPS),
    localparam int DW = clog2_min1(INT_DOWNSAMPLING)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_en,
    input  logic [AW-1:0]                    wr_addr,
    input  logic signed [INT_COEF_WIDTH-1:0] wr_data,
    input  logic                             deci_en,
    input  logic [DW-1:0]                    deci_data,
    input  logic [AW-1:0]                    rd_addr,
    output logic signed [INT_COEF_WIDTH-1:0] rd_coef,
    output logic [DW-1:0]                    deci,
    output logic                             err
);

    logic signed [INT_COEF_WIDTH-1:0] coef_q [INT_NUMBER_OF_TAPS];
    logic [DW-1:0] deci_q;
    logic          err_q;
    logic          coef_ok;
    logic          deci_ok;

    assign coef_ok = wr_en && (int'(wr_addr) < INT_NUMBER_OF_TAPS);
    assign deci_ok = deci_en && (int'(deci_data) < INT_DOWNSAMPLING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < INT_NUMBER_OF_TAPS; i++) begin
                coef_q[i] <= '0;
            end
            deci_q <= DW'(INT_DOWNSAMPLING - 1);
            err_q  <= 1'b0;
        end else begin
            if (coef_ok) begin
                coef_q[wr_addr] <= wr_data;
            end
            if (deci_ok) begin
                deci_q <= deci_data;
            end
            // Both write ports may fail in one cycle; they share a single pulse.
            err_q <= (wr_en && !coef_ok) || (deci_en && !deci_ok);
        end
    end

    assign rd_coef = (int'(rd_addr) < INT_NUMBER_OF_TAPS) ? coef_q[rd_addr] : '0;
    assign deci    = deci_q;
    assign err     = err_q;

endmodule

// File: rtl/ddc_cfg_sequencer.sv
// Streams shadow coefficients and decimation into the DDC on commit, then
// masks DDC output until the filter pipeline has flushed.
module ddc_cfg_sequencer import ddc_pkg::*; #(
    parameter int INT_NUMBER_OF_TAPS = DEF_NUMBER_OF_TAPS,
    parameter int INT_COEF_WIDTH     = DEF_COEF_WIDTH,
    parameter int INT_DOWNSAMPLING   = DEF_DOWNSAMPLING,
    parameter int INT_FLUSH_SAMPLES  = INT_NUMBER_OF_TAPS,
    localparam int AW = clog2_min1(INT_NUMBER_OF_TAPS),
    localparam int DW = clog2_min1(INT_DOWNSAMPLING),
    localparam int FW = clog2_min1(INT_FLUSH_SAMPLES + 1)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_wr_valid,
    output logic                             o_wr_ready,
    input  logic [AW-1:0]                    i_wr_addr,
    input  logic signed [INT_COEF_WIDTH-1:0] i_wr_data,
    input  logic                             i_deci_valid,
    input  logic [DW-1:0]                    i_deci_data,
    input  logic                             i_commit,
    output logic                             o_fir_cmd_valid,
    output logic [AW-1:0]                    o_fir_cmd_coeffsel,
    output logic signed [INT_COEF_WIDTH-1:0] o_fir_cmd_data,
    output logic                             o_deci_cmd_valid,
    output logic [DW-1:0]                    o_deci_cmd_data,
    input  logic                             i_ddc_valid,
    output logic                             o_ddc_valid_gated,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_err
);

    localparam logic [AW-1:0] KLast      = AW'(INT_NUMBER_OF_TAPS - 1);
    localparam logic [FW-1:0] FlushLimit = FW'(INT_FLUSH_SAMPLES);

    ddc_state_e state_q, state_d;
    logic          pending_q, pending_d;
    logic [AW-1:0] k_q, k_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;

    logic signed [INT_COEF_WIDTH-1:0] rd_coef;
    logic [DW-1:0] shadow_deci;
    logic          fir_active;
    logic          deci_active;

    assign fir_active  = (state_q == StLoadCoef);
    assign deci_active = (state_q == StLoadDeci);

    ddc_cfg_shadow #(
        .INT_NUMBER_OF_TAPS (INT_NUMBER_OF_TAPS),
        .INT_COEF_WIDTH     (INT_COEF_WIDTH),
        .INT_DOWNSAMPLING   (INT_DOWNSAMPLING)
    ) u_shadow (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (i_wr_valid && o_wr_ready),
        .wr_addr   (i_wr_addr),
        .wr_data   (i_wr_data),
        .deci_en   (i_deci_valid && !deci_active),
        .deci_data (i_deci_data),
        .rd_addr   (k_q),
        .rd_coef   (rd_coef),
        .deci      (shadow_deci),
        .err       (o_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pending_q   <= 1'b0;
            k_q         <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            k_q         <= k_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        k_d         = k_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (i_commit || pending_q) begin
                    state_d   = StLoadCoef;
                    pending_d = 1'b0;
                    k_d       = '0;
                end
            end
            StLoadCoef: begin
                if (k_q == KLast) begin
                    k_d     = '0;
                    state_d = StLoadDeci;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            StLoadDeci: begin
                flush_cnt_d = '0;
                state_d     = StFlush;
            end
            StFlush: begin
                if (INT_FLUSH_SAMPLES == 0) begin
                    state_d = StDone;
                end else if (i_ddc_valid) begin
                    flush_cnt_d = flush_cnt_q + 1'b1;
                    if (flush_cnt_d == FlushLimit) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Commits arriving mid-sequence coalesce into one rerun.
        if (i_commit && (state_q != StIdle)) begin
            pending_d = 1'b1;
        end
    end

    assign o_wr_ready         = !fir_active;
    assign o_fir_cmd_valid    = fir_active;
    assign o_fir_cmd_coeffsel = fir_active ? k_q : '0;
    assign o_fir_cmd_data     = fir_active ? rd_coef : '0;
    assign o_deci_cmd_valid   = deci_active;
    assign o_deci_cmd_data    = deci_active ? shadow_deci : '0;
    assign o_ddc_valid_gated  = i_ddc_valid && (state_q == StIdle);
    assign o_busy             = (state_q != StIdle);
    assign o_done             = (state_q == StDone);

endmodule

// File: tb/tb_ddc_cfg_sequencer.sv
// Directed bench for ddc_cfg_sequencer: commit timing, flush gating, commit
// coalescing, range errors, write back-pressure and mid-sequence reset.
module tb_ddc_cfg_sequencer;

    localparam int TAPS = 5;
    localparam int CW   = 10;
    localparam int DS   = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 i_wr_valid = 1'b0;
    logic                 o_wr_ready;
    logic [2:0]           i_wr_addr = '0;
    logic signed [CW-1:0] i_wr_data = '0;
    logic                 i_deci_valid = 1'b0;
    logic [3:0]           i_deci_data = '0;
    logic                 i_commit = 1'b0;
    logic                 o_fir_cmd_valid;
    logic [2:0]           o_fir_cmd_coeffsel;
    logic signed [CW-1:0] o_fir_cmd_data;
    logic                 o_deci_cmd_valid;
    logic [3:0]           o_deci_cmd_data;
    logic                 i_ddc_valid = 1'b0;
    logic                 o_ddc_valid_gated;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_err;

    int checks = 0;
    int errors = 0;
    logic signed [CW-1:0] exp_coef [TAPS];

    always #5 clk = ~clk;

    ddc_cfg_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .i_wr_valid         (i_wr_valid),
        .o_wr_ready         (o_wr_ready),
        .i_wr_addr          (i_wr_addr),
        .i_wr_data          (i_wr_data),
        .i_deci_valid       (i_deci_valid),
        .i_deci_data        (i_deci_data),
        .i_commit           (i_commit),
        .o_fir_cmd_valid    (o_fir_cmd_valid),
        .o_fir_cmd_coeffsel (o_fir_cmd_coeffsel),
        .o_fir_cmd_data     (o_fir_cmd_data),
        .o_deci_cmd_valid   (o_deci_cmd_valid),
        .o_deci_cmd_data    (o_deci_cmd_data),
        .i_ddc_valid        (i_ddc_valid),
        .o_ddc_valid_gated  (o_ddc_valid_gated),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_err              (o_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered one step after the commit edge; leaves in IDLE after DONE.
    task automatic seq_check(input string tag, input logic [31:0] exp_deci);
        for (int j = 0; j < TAPS; j++) begin
            check({tag, "_fir_valid"}, o_fir_cmd_valid, 1);
            check({tag, "_fir_sel"}, o_fir_cmd_coeffsel, j);
            check({tag, "_fir_data"}, o_fir_cmd_data, exp_coef[j]);
            tick();
        end
        check({tag, "_deci_valid"}, o_deci_cmd_valid, 1);
        check({tag, "_deci_data"}, o_deci_cmd_data, exp_deci);
        check({tag, "_fir_off"}, {o_fir_cmd_valid, o_fir_cmd_coeffsel, o_fir_cmd_data}, 0);
        tick();
        for (int j = 0; j < TAPS; j++) begin
            i_ddc_valid = 1'b1;
            #1;
            check({tag, "_gated"}, o_ddc_valid_gated, 0);
            check({tag, "_early_done"}, o_done, 0);
            tick();
        end
        i_ddc_valid = 1'b0;
        check({tag, "_done"}, o_done, 1);
        check({tag, "_done_cmd_off"}, {o_deci_cmd_valid, o_deci_cmd_data}, 0);
        tick();
        check({tag, "_done_once"}, o_done, 0);
        check({tag, "_idle"}, o_busy, 0);
    endtask

    task automatic commit_pulse();
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", o_busy, 0);
        check("rst_wr_ready", o_wr_ready, 1);
        check("rst_cmds", {o_fir_cmd_valid, o_deci_cmd_valid, o_done, o_err}, 0);
        #10 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_auto_commit", o_busy, 0);
        end

        // Out-of-range coefficient address and decimation in one cycle
        i_wr_valid = 1'b1; i_wr_addr = 3'd7; i_wr_data = 10'sd100;
        i_deci_valid = 1'b1; i_deci_data = 4'd12;
        #1 check("err_before", o_err, 0);
        tick();
        i_wr_valid = 1'b0; i_deci_valid = 1'b0;
        check("err_pulse", o_err, 1);
        tick();
        check("err_single", o_err, 0);

        i_wr_valid = 1'b1; i_wr_addr = 3'd5; i_wr_data = 10'sd50;
        tick();
        i_wr_valid = 1'b0;
        check("err_addr_taps", o_err, 1);
        i_deci_valid = 1'b1; i_deci_data = 4'd10;
        tick();
        i_deci_valid = 1'b0;
        check("err_deci_ds", o_err, 1);
        tick();
        check("err_clear", o_err, 0);

        commit_pulse();
        for (int j = 0; j < TAPS; j++) exp_coef[j] = '0;
        seq_check("rdback", 9);

        // Load 1..4, then coef[4]=5 and deci=4 in the commit cycle itself
        for (int j = 0; j < 4; j++) begin
            i_wr_valid = 1'b1; i_wr_addr = 3'(j); i_wr_data = 10'(j + 1);
            tick();
        end
        i_wr_addr = 3'd4; i_wr_data = 10'sd5;
        i_deci_valid = 1'b1; i_deci_data = 4'd4;
        i_commit = 1'b1;
        tick();
        i_wr_valid = 1'b0; i_deci_valid = 1'b0; i_commit = 1'b0;
        for (int j = 0; j < TAPS; j++) exp_coef[j] = 10'(j + 1);
        check("main_wr_ready", o_wr_ready, 0);
        seq_check("main", 4);
        check("main_no_err", o_err, 0);
        i_ddc_valid = 1'b1;
        #1 check("pass_through", o_ddc_valid_gated, 1);
        i_ddc_valid = 1'b0;

        // Three commits during FLUSH coalesce into one rerun
        commit_pulse();
        repeat (TAPS + 1) tick();
        check("in_flush", o_busy, 1);
        for (int i = 0; i < 3; i++) begin
            commit_pulse();
            tick();
        end
        for (int j = 0; j < TAPS; j++) begin
            i_ddc_valid = 1'b1;
            tick();
        end
        i_ddc_valid = 1'b0;
        check("coal_done", o_done, 1);
        tick();
        check("coal_idle_gap", o_fir_cmd_valid, 0);
        tick();
        seq_check("rerun", 4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("no_second_rerun", o_busy, 0);
        end

        // Write held during LOAD_COEF is taken only once LOAD_DECI begins
        commit_pulse();
        i_wr_valid = 1'b1; i_wr_addr = 3'd4; i_wr_data = 10'sd77;
        for (int j = 0; j < TAPS; j++) begin
            check("bp_ready_low", o_wr_ready, 0);
            check("bp_fir_data", o_fir_cmd_data, exp_coef[j]);
            tick();
        end
        check("bp_ready_deci", o_wr_ready, 1);
        check("bp_deci_valid", o_deci_cmd_valid, 1);
        tick();
        i_wr_valid = 1'b0;
        check("bp_no_err", o_err, 0);
        for (int j = 0; j < TAPS; j++) begin
            i_ddc_valid = 1'b1;
            tick();
        end
        i_ddc_valid = 1'b0;
        tick();
        commit_pulse();
        exp_coef[4] = 10'sd77;
        seq_check("bp_taken", 4);

        // Reset asserted during the third FIR strobe
        commit_pulse();
        tick();
        tick();
        check("mid_fir_valid", o_fir_cmd_valid, 1);
        check("mid_fir_sel", o_fir_cmd_coeffsel, 2);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_fir", {o_fir_cmd_valid, o_fir_cmd_coeffsel, o_fir_cmd_data}, 0);
        check("mid_rst_deci", {o_deci_cmd_valid, o_deci_cmd_data}, 0);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_ready", o_wr_ready, 1);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_rst_quiet", {o_busy, o_fir_cmd_valid, o_deci_cmd_valid, o_done}, 0);
        end
        commit_pulse();
        for (int j = 0; j < TAPS; j++) exp_coef[j] = '0;
        seq_check("post_rst", 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
